// File: rtl/ifm_pingpong_reader.sv
// ifm_pingpong_reader: next-layer reader of the two-bank IFM ping-pong memory.
// Owns the bank select, streams the read bank as pixel pairs through a
// 2-entry skid FIFO so backpressure never drops synchronous-RAM read data.
// Optional build macro IFM_READER_PERF_EN adds stall/frame counters.
module ifm_pingpong_reader #(
    parameter int DATA_WIDTH       = 32,
    parameter int IFM_SIZE         = 28,
    parameter int ADDRESS_SIZE_IFM = $clog2(IFM_SIZE * IFM_SIZE)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        write_frame_done,
    output logic                        write_ready,
    output logic [$clog2(2)-1:0]        ifm_sel,
    output logic                        ifm_enable_read_A_next,
    output logic                        ifm_enable_read_B_next,
    output logic [ADDRESS_SIZE_IFM-1:0] ifm_address_read_A_next,
    output logic [ADDRESS_SIZE_IFM-1:0] ifm_address_read_B_next,
    input  logic [DATA_WIDTH-1:0]       data_in_A,
    input  logic [DATA_WIDTH-1:0]       data_in_B,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_data_a,
    output logic [DATA_WIDTH-1:0]       out_data_b,
    output logic                        out_last,
    output logic                        overflow_err
`ifdef IFM_READER_PERF_EN
    ,
    output logic [31:0]                 stall_cycles,
    output logic [15:0]                 frames_done
`endif
);

    localparam int PIXELS = IFM_SIZE * IFM_SIZE;
    localparam int PAIRS  = (PIXELS + 1) / 2;
    localparam logic [ADDRESS_SIZE_IFM-1:0] LAST_PAIR = ADDRESS_SIZE_IFM'(PAIRS - 1);
    localparam bit ODD_PIXELS = (PIXELS % 2) == 1;

    typedef enum logic [1:0] {IDLE, SWAP, READ, DRAIN} state_t;

    state_t                      state, state_next;
    logic                        pending;
    logic [ADDRESS_SIZE_IFM-1:0] pair_idx;
    logic                        inflight, inflight_last, inflight_b_en;
    logic [DATA_WIDTH-1:0]       fifo_a [2];
    logic [DATA_WIDTH-1:0]       fifo_b [2];
    logic [1:0]                  fifo_last;
    logic                        rd_ptr, wr_ptr;
    logic [1:0]                  fifo_count;
    logic [2:0]                  occupancy;
    logic                        issue, issue_last, pop, push, fifo_drains;

    assign out_valid   = (fifo_count != 2'd0);
    assign pop         = out_valid && out_ready;
    assign push        = inflight;
    assign write_ready = !pending;

    // Slots committed after this edge: buffered pairs plus the read in flight,
    // minus the pair leaving now. Counting the pop keeps 1 pair/cycle.
    assign occupancy   = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
    assign issue       = (state == READ) && (occupancy < 3'd2);
    assign issue_last  = (pair_idx == LAST_PAIR);
    assign fifo_drains = !inflight && ((fifo_count == 2'd0) || (fifo_count == 2'd1 && pop));

    assign out_data_a  = fifo_a[rd_ptr];
    assign out_data_b  = fifo_b[rd_ptr];
    assign out_last    = out_valid && fifo_last[rd_ptr];

    // Read-port drive: pair k reads pixels 2k/2k+1; the unpaired last pixel of an odd frame leaves port B idle
    always_comb begin
        ifm_enable_read_A_next  = issue;
        ifm_enable_read_B_next  = issue && !(ODD_PIXELS && issue_last);
        ifm_address_read_A_next = '0;
        ifm_address_read_B_next = '0;
        if (issue) begin
            ifm_address_read_A_next = {pair_idx[ADDRESS_SIZE_IFM-2:0], 1'b0};
        end
        if (ifm_enable_read_B_next) begin
            ifm_address_read_B_next = {pair_idx[ADDRESS_SIZE_IFM-2:0], 1'b1};
        end
    end

    // Next-state logic: a filled bank kicks off a swap, draining returns to idle or straight into the next swap
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pending || write_frame_done) state_next = SWAP;
            SWAP:    state_next = READ;
            READ:    if (issue && issue_last) state_next = DRAIN;
            DRAIN:   if (fifo_drains) state_next = (pending || write_frame_done) ? SWAP : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Bank ownership: pending flag (set wins over the swap clear), overflow flag, bank select and pair counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending      <= 1'b0;
            overflow_err <= 1'b0;
            ifm_sel      <= '0;
            pair_idx     <= '0;
        end else begin
            if (write_frame_done) begin
                pending <= 1'b1;
                if (pending && state != SWAP) overflow_err <= 1'b1;
            end else if (state == SWAP) begin
                pending <= 1'b0;
            end
            if (state == SWAP) begin
                ifm_sel  <= ~ifm_sel;
                pair_idx <= '0;
            end else if (issue) begin
                pair_idx <= pair_idx + 1'b1;
            end
        end
    end

    // Capture the RAM data one cycle after the read and push it into the skid FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            inflight_b_en <= 1'b0;
            rd_ptr        <= 1'b0;
            wr_ptr        <= 1'b0;
            fifo_count    <= 2'd0;
            fifo_last     <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                fifo_a[i] <= '0;
                fifo_b[i] <= '0;
            end
        end else begin
            inflight      <= issue;
            inflight_last <= issue && issue_last;
            inflight_b_en <= ifm_enable_read_B_next;
            if (push) begin
                fifo_a[wr_ptr]    <= data_in_A;
                fifo_b[wr_ptr]    <= inflight_b_en ? data_in_B : '0;
                fifo_last[wr_ptr] <= inflight_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
        end
    end

`ifdef IFM_READER_PERF_EN
    // Saturating stall and completed-frame counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            frames_done  <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
            if (pop && out_last && frames_done != '1) frames_done <= frames_done + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ifm_pingpong_reader.sv
// tb_ifm_pingpong_reader: directed bench for the IFM ping-pong reader,
// a 28x28 instance for streaming/swap/overflow/reset and a 5x5 instance
// for the odd-pixel-count last pair.
module tb_ifm_pingpong_reader;

    localparam int DW  = 32;
    localparam int AW  = 10;
    localparam int AW5 = 5;

    logic clk = 1'b0;
    logic rst_n;

    logic          wfd, write_ready, en_a, en_b, out_valid, out_ready, out_last, overflow_err;
    logic [0:0]    ifm_sel;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] din_a, din_b, oda, odb;

    logic           s_wfd, s_write_ready, s_en_a, s_en_b, s_out_valid, s_out_ready, s_out_last, s_overflow_err;
    logic [0:0]     s_ifm_sel;
    logic [AW5-1:0] s_addr_a, s_addr_b;
    logic [DW-1:0]  s_din_a, s_din_b, s_oda, s_odb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ifm_pingpong_reader #(.DATA_WIDTH(DW), .IFM_SIZE(28), .ADDRESS_SIZE_IFM(AW)) dut (
        .clk(clk), .rst_n(rst_n), .write_frame_done(wfd), .write_ready(write_ready),
        .ifm_sel(ifm_sel), .ifm_enable_read_A_next(en_a), .ifm_enable_read_B_next(en_b),
        .ifm_address_read_A_next(addr_a), .ifm_address_read_B_next(addr_b),
        .data_in_A(din_a), .data_in_B(din_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_data_a(oda), .out_data_b(odb), .out_last(out_last), .overflow_err(overflow_err)
    );

    ifm_pingpong_reader #(.DATA_WIDTH(DW), .IFM_SIZE(5), .ADDRESS_SIZE_IFM(AW5)) dut5 (
        .clk(clk), .rst_n(rst_n), .write_frame_done(s_wfd), .write_ready(s_write_ready),
        .ifm_sel(s_ifm_sel), .ifm_enable_read_A_next(s_en_a), .ifm_enable_read_B_next(s_en_b),
        .ifm_address_read_A_next(s_addr_a), .ifm_address_read_B_next(s_addr_b),
        .data_in_A(s_din_a), .data_in_B(s_din_b), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_data_a(s_oda), .out_data_b(s_odb), .out_last(s_out_last), .overflow_err(s_overflow_err)
    );

    // Pixel content of the model memory: tags the bank and address
    function automatic logic [31:0] pat(input logic bank, input int addr);
        return 32'hA000_0000 | (32'(bank) << 16) | 32'(addr);
    endfunction

    // Synchronous-read RAM models; disabled ports return junk so zeroing is visible
    always @(posedge clk) begin
        din_a   <= en_a   ? pat(ifm_sel[0],   int'(addr_a))   : 32'hDEAD_BEEF;
        din_b   <= en_b   ? pat(ifm_sel[0],   int'(addr_b))   : 32'hDEAD_BEEF;
        s_din_a <= s_en_a ? pat(s_ifm_sel[0], int'(s_addr_a)) : 32'hDEAD_BEEF;
        s_din_b <= s_en_b ? pat(s_ifm_sel[0], int'(s_addr_b)) : 32'hDEAD_BEEF;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Consume pairs of a 28x28 frame from the given bank, optionally pulsing write_frame_done at pair pulse_at
    task automatic run_frame(input logic bank, input int ready_pct, input int pulse_at,
                             input int stop_at, output int cycles);
        int          k = 0;
        bit          stalled = 0;
        bit          pulsed = 0;
        logic [63:0] held_data = '0;
        logic        held_last = 1'b0;
        cycles = 0;
        while (k < stop_at && cycles < 4000) begin
            out_ready = ($urandom_range(0, 99) < ready_pct);
            if (stalled) begin
                checkOutput("stall_valid", out_valid, 1);
                checkOutput("stall_data", {oda, odb}, held_data);
                checkOutput("stall_last", out_last, held_last);
            end
            stalled = 0;
            if (out_valid) begin
                if (out_ready) begin
                    checkOutput("pair_data", {oda, odb}, {pat(bank, 2 * k), pat(bank, 2 * k + 1)});
                    checkOutput("pair_last", out_last, k == 391);
                    k++;
                end else begin
                    stalled   = 1;
                    held_data = {oda, odb};
                    held_last = out_last;
                end
            end
            if (k == pulse_at && !pulsed) begin
                wfd    = 1'b1;
                pulsed = 1;
            end
            step();
            cycles++;
            wfd = 1'b0;
        end
        if (k < stop_at) checkOutput("frame_timeout", k, stop_at);
    endtask

    initial begin
        int cyc;
        int k5;
        bit seen_last_issue;
        rst_n = 1'b0; wfd = 1'b0; out_ready = 1'b0; s_wfd = 1'b0; s_out_ready = 1'b0;
        #1;
        checkOutput("rst_sel", ifm_sel, 0);
        checkOutput("rst_write_ready", write_ready, 1);
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_overflow", overflow_err, 0);
        step(); step();
        rst_n = 1'b1;
        step();

        // Frame 1: full rate, a second filled bank reported mid-read
        wfd = 1'b1; out_ready = 1'b1;
        step();
        wfd = 1'b0;
        checkOutput("sel_before_swap", ifm_sel, 0);
        checkOutput("pending_after_pulse", write_ready, 0);
        step();
        checkOutput("sel_after_swap", ifm_sel, 1);
        checkOutput("first_issue", {en_a, en_b, 6'b0, 22'(addr_a), 22'(addr_b)}, {1'b1, 1'b1, 6'b0, 22'd0, 22'd1});
        checkOutput("valid_lat1", out_valid, 0);
        step();
        checkOutput("valid_lat2", out_valid, 0);
        step();
        checkOutput("first_valid", out_valid, 1);
        run_frame(1'b1, 100, 200, 392, cyc);
        checkOutput("full_rate_cycles", cyc, 392);
        checkOutput("sel_at_last_pop", ifm_sel, 1);
        checkOutput("pending_until_swap", write_ready, 0);
        step();
        checkOutput("sel_toggles_back", ifm_sel, 0);
        checkOutput("write_ready_after_swap", write_ready, 1);
        checkOutput("no_overflow", overflow_err, 0);

        // Frame 2: bank 0, random backpressure
        run_frame(1'b0, 50, -1, 392, cyc);
        step(); step(); step();
        checkOutput("idle_valid", out_valid, 0);
        checkOutput("idle_enable", en_a, 0);
        checkOutput("idle_sel", ifm_sel, 0);
        checkOutput("idle_overflow", overflow_err, 0);

        // Frame 3: stalled reader, overflow on a third report, then reset at pair 100
        out_ready = 1'b0;
        wfd = 1'b1;
        step();
        wfd = 1'b0;
        for (int i = 0; i < 6; i++) step();
        checkOutput("stalled_valid", out_valid, 1);
        checkOutput("stalled_head", {oda, odb}, {pat(1'b1, 0), pat(1'b1, 1)});
        checkOutput("stalled_no_issue", en_a, 0);
        wfd = 1'b1;
        step();
        wfd = 1'b0;
        checkOutput("second_pending", write_ready, 0);
        checkOutput("second_no_overflow", overflow_err, 0);
        wfd = 1'b1;
        step();
        wfd = 1'b0;
        checkOutput("overflow_set", overflow_err, 1);
        step(); step(); step();
        checkOutput("overflow_sticky", overflow_err, 1);
        checkOutput("stalled_head_hold", {oda, odb}, {pat(1'b1, 0), pat(1'b1, 1)});
        run_frame(1'b1, 100, -1, 100, cyc);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_valid", out_valid, 0);
        checkOutput("arst_data", {oda, odb}, 64'd0);
        checkOutput("arst_last", out_last, 0);
        checkOutput("arst_enables", {en_a, en_b}, 2'b00);
        checkOutput("arst_addr", addr_a, 0);
        checkOutput("arst_sel", ifm_sel, 0);
        checkOutput("arst_overflow", overflow_err, 0);
        checkOutput("arst_write_ready", write_ready, 1);
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checkOutput("post_rst_quiet", {out_valid, en_a}, 2'b00);
        end
        checkOutput("post_rst_sel", ifm_sel, 0);

        // 5x5 frame: 13 pairs, the last one unpaired
        s_wfd = 1'b1; s_out_ready = 1'b1;
        step();
        s_wfd = 1'b0;
        k5 = 0;
        seen_last_issue = 0;
        for (int c = 0; c < 200 && k5 < 13; c++) begin
            if (s_en_a && s_addr_a == 5'd24) begin
                seen_last_issue = 1;
                checkOutput("n25_last_b_en", s_en_b, 0);
            end
            if (s_out_valid) begin
                checkOutput("n25_a", s_oda, pat(1'b1, 2 * k5));
                checkOutput("n25_b", s_odb, (k5 == 12) ? 32'd0 : pat(1'b1, 2 * k5 + 1));
                checkOutput("n25_last", s_out_last, k5 == 12);
                k5++;
            end
            step();
        end
        checkOutput("n25_pairs", k5, 13);
        checkOutput("n25_last_issue_seen", seen_last_issue, 1);
        step(); step();
        checkOutput("n25_idle", s_out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifm_pingpong_reader.md
Name: ifm_pingpong_reader

Overview:
- Next-layer side of the two-bank IFM ping-pong memory array.
- Owns bank selection (ifm_sel). Swaps banks when the previous layer reports a filled bank and the current read pass has finished.
- Streams the read bank in raster order, two pixels per cycle, on ports A and B. Data leaves on a valid/ready interface with a 2-entry skid FIFO, so downstream backpressure never loses synchronous-RAM read data.

Parameters:
- DATA_WIDTH, 32, pixel word width.
- IFM_SIZE, 28, feature-map side; pixel count N = IFM_SIZE*IFM_SIZE.
- ADDRESS_SIZE_IFM, $clog2(IFM_SIZE*IFM_SIZE), bank address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- write_frame_done  in  1  single-cycle pulse: previous layer finished filling the write bank.
- write_ready  out  1  write bank free; previous layer may write.
- ifm_sel  out  $clog2(2)  bank select. Write bank = Mem(ifm_sel+1); read bank = the other.
- ifm_enable_read_A_next  out  1  port-A read enable.
- ifm_enable_read_B_next  out  1  port-B read enable.
- ifm_address_read_A_next  out  ADDRESS_SIZE_IFM  port-A address (even pixel).
- ifm_address_read_B_next  out  ADDRESS_SIZE_IFM  port-B address (odd pixel).
- data_in_A  in  DATA_WIDTH  array data_out_A_for_next1, valid 1 cycle after enable.
- data_in_B  in  DATA_WIDTH  array data_out_B_for_next1, valid 1 cycle after enable.
- out_valid  out  1  output pair valid.
- out_ready  in  1  downstream accepts.
- out_data_a  out  DATA_WIDTH  pixel 2k.
- out_data_b  out  DATA_WIDTH  pixel 2k+1; 0 for the unpaired last pixel when N is odd.
- out_last  out  1  marks final pair of the frame.
- overflow_err  out  1  sticky: write_frame_done arrived while a full bank was already pending.

Behaviour:
- Reset (async, rst_n=0), all outputs and state cleared:
  - ifm_sel=0, pending=0, write_ready=1.
  - Read enables=0, addresses=0, out_valid=0, out_data_*=0, out_last=0, overflow_err=0.
  - FIFO empty, in-flight cleared, state=IDLE.
  - A reset mid-frame abandons the frame; no partial output after release.
- pending flag:
  - Set by write_frame_done.
  - write_ready = !pending.
  - Pulse while pending=1: pending unchanged, overflow_err<=1.
  - Pulse in the same cycle as a swap re-sets pending (set wins over clear).
- State IDLE: if pending, go to SWAP.
- State SWAP (1 cycle): ifm_sel<=~ifm_sel; pending<=0; pair counter k<=0; go to READ.
- State READ:
  - Issue a pair when (fifo_count + inflight) < 2.
  - On issue: both enables=1, A addr = 2k, B addr = 2k+1.
  - For the final pair of an odd N, B enable=0 and B is zeroed on capture.
  - inflight<=1 on issue; the next cycle pushes {data_in_A, data_in_B, last} into the FIFO.
  - After issuing pair ceil(N/2)-1, go to DRAIN.
- State DRAIN: when FIFO empty and inflight=0, go to IDLE (SWAP directly if pending).
- Output:
  - out_valid = FIFO not empty; pop on out_valid && out_ready.
  - Data is held stable while out_valid=1 and out_ready=0.
- Latency: first out_valid 3 cycles after the write_frame_done pulse when in IDLE (SWAP, issue, capture).
- Throughput: 1 pair/cycle with out_ready held at 1.
- The writer may fill the new write bank during READ/DRAIN; this is ping-pong concurrency.
- Addresses never exceed N-1; no wrap within a frame. k resets to 0 at each SWAP.

Optional Feature:
- Macro: IFM_READER_PERF_EN.
- Defined:
  - Extra outputs stall_cycles[31:0] (counts out_valid && !out_ready) and frames_done[15:0] (increments on pop with out_last).
  - Both saturate, clear on reset only.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset then single write_frame_done, IFM_SIZE=28, out_ready=1:
  - ifm_sel goes 0->1 one cycle after the pulse.
  - 392 pairs stream: pair 0 = (addr 0, 1), pair 391 = (782, 783) with out_last=1.
  - First out_valid 3 cycles after the pulse; state returns to IDLE.
- Random out_ready (50%) over full frame:
  - No pair dropped or duplicated; order matches model memory.
  - Data stable during stalls; never more than 2 reads outstanding plus buffered.
- Second write_frame_done mid-READ:
  - write_ready=0 until the swap.
  - Immediately after out_last is popped, ifm_sel toggles back to 0 and a new frame streams.
  - overflow_err stays 0.
- Two write_frame_done pulses with no swap between (reader stalled, out_ready=0): overflow_err=1 and stays set.
- IFM_SIZE=5 (N=25): 13 pairs; last pair B enable=0, out_data_b=0, out_last=1.
- rst_n asserted at pair 100 of 392: all outputs zero asynchronously; after release, state=IDLE with ifm_sel=0 and no output until the next write_frame_done.
